// File: rtl/conv_sa_post_if.sv
// Handshake and control bundle between the post-row sequencing controller and
// its environment (array column sums, tile control, result FIFO credits).
interface conv_sa_post_if #(
    parameter int M_BLK = 8
);
    localparam int SEL_W = (M_BLK > 1) ? $clog2(M_BLK) : 1;
    localparam int NB_W  = $clog2(M_BLK) + 1;

    logic             start;
    logic [NB_W-1:0]  cfg_n_blk;
    logic [15:0]      cfg_n_ic;
    logic             busy;
    logic             done;
    logic             sum_vld;
    logic             sum_rdy;
    logic             in_rstp;
    logic [SEL_W-1:0] in_sel;
    logic             y_vld;
    logic [SEL_W-1:0] y_blk;
    logic             out_pop;

    modport master (
        input  start, cfg_n_blk, cfg_n_ic, sum_vld, out_pop,
        output busy, done, sum_rdy, in_rstp, in_sel, y_vld, y_blk
    );

    modport slave (
        output start, cfg_n_blk, cfg_n_ic, sum_vld, out_pop,
        input  busy, done, sum_rdy, in_rstp, in_sel, y_vld, y_blk
    );
endinterface

// File: rtl/conv_sa_post_ctrl.sv
// Post-row sequencer: walks block (inner) and input-channel chunk (outer)
// indices, drives in_rstp/in_sel, and tracks final results with output credits.
module conv_sa_post_ctrl #(
    parameter int M_BLK     = 8,
    parameter int P         = 16,
    parameter int POST_LAT  = 3,
    parameter int OUT_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rstn,
    conv_sa_post_if.master bus
);
    localparam int SEL_W  = (M_BLK > 1) ? $clog2(M_BLK) : 1;
    localparam int NB_W   = $clog2(M_BLK) + 1;
    localparam int CR_W   = $clog2(OUT_DEPTH + 1);
    // Token visible at stage k in cycle t+1+k; y_vld must appear at t+POST_LAT+P.
    localparam int STAGES = POST_LAT + P - 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state_q;
    logic [SEL_W-1:0]   blk_q;
    logic [15:0]        ic_q;
    logic [NB_W-1:0]    n_blk_q;
    logic [15:0]        n_ic_q;
    logic [CR_W-1:0]    credits_q, credits_d;
    logic               in_rstp_q;
    logic [SEL_W-1:0]   in_sel_q;
    logic               busy_q;
    logic               done_q;
    logic [STAGES:0]             vld_pipe;
    logic [STAGES:0][SEL_W-1:0]  blk_pipe;

    logic last_ic, last_blk, sum_rdy, accept, final_beat, pipe_empty;

    assign last_ic    = (ic_q == n_ic_q - 16'd1);
    assign last_blk   = (NB_W'(blk_q) == n_blk_q - NB_W'(1));
    assign sum_rdy    = (state_q == RUN) && (!last_ic || (credits_q != '0));
    assign accept     = bus.sum_vld && sum_rdy;
    assign final_beat = accept && last_ic;
    // The token sitting in the last stage is the one on y_vld this cycle.
    assign pipe_empty = (vld_pipe[STAGES-1:0] == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            blk_q     <= '0;
            ic_q      <= '0;
            n_blk_q   <= '0;
            n_ic_q    <= '0;
            in_rstp_q <= 1'b0;
            in_sel_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            in_rstp_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        n_blk_q <= bus.cfg_n_blk;
                        n_ic_q  <= bus.cfg_n_ic;
                        blk_q   <= '0;
                        ic_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= (bus.cfg_n_blk == '0 || bus.cfg_n_ic == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        in_sel_q  <= blk_q;
                        in_rstp_q <= (ic_q == '0);
                        if (last_blk) begin
                            blk_q <= '0;
                            if (last_ic) state_q <= DRAIN;
                            else         ic_q    <= ic_q + 16'd1;
                        end else begin
                            blk_q <= blk_q + SEL_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (pipe_empty) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        credits_d = credits_q;
        if (final_beat && !bus.out_pop)
            credits_d = credits_q - CR_W'(1);
        else if (bus.out_pop && !final_beat && credits_q != CR_W'(OUT_DEPTH))
            credits_d = credits_q + CR_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credits_q <= CR_W'(OUT_DEPTH);
            vld_pipe  <= '0;
            blk_pipe  <= '0;
        end else begin
            credits_q <= credits_d;
            vld_pipe  <= {vld_pipe[STAGES-1:0], final_beat};
            blk_pipe  <= {blk_pipe[STAGES-1:0], blk_q};
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sum_rdy = sum_rdy;
    assign bus.in_rstp = in_rstp_q;
    assign bus.in_sel  = in_sel_q;
    assign bus.y_vld   = vld_pipe[STAGES];
    assign bus.y_blk   = blk_pipe[STAGES];
endmodule

// File: tb/tb_conv_sa_post_ctrl.sv
// Directed bench for conv_sa_post_ctrl: sequencing, latency, credits, reset abort.
module tb_conv_sa_post_ctrl;
    localparam int M_BLK = 8, P = 16, POST_LAT = 3, OUT_DEPTH = 4;
    localparam int LAT = POST_LAT + P;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    conv_sa_post_if #(.M_BLK(M_BLK)) sa_if ();

    conv_sa_post_ctrl #(.M_BLK(M_BLK), .P(P), .POST_LAT(POST_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (sa_if.master)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_q[$], rstp_q[$], sel_q[$], ycyc_q[$], yblk_q[$], done_q[$];
    logic prev_acc = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Log accepts, the beat flags one cycle later, results and done pulses.
    always @(negedge clk) begin
        if (prev_acc) begin
            rstp_q.push_back(int'(sa_if.in_rstp));
            sel_q.push_back(int'(sa_if.in_sel));
        end
        prev_acc = rstn && sa_if.sum_vld && sa_if.sum_rdy;
        if (prev_acc)    acc_q.push_back(cyc);
        if (sa_if.y_vld) begin ycyc_q.push_back(cyc); yblk_q.push_back(int'(sa_if.y_blk)); end
        if (sa_if.done)  done_q.push_back(cyc);
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_logs();
        acc_q.delete(); rstp_q.delete(); sel_q.delete();
        ycyc_q.delete(); yblk_q.delete(); done_q.delete();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_q.size() == 0 && n < budget) begin tick(1); n++; end
        chk({tag, "_done_seen"}, done_q.size(), 1);
    endtask

    task automatic start_tile(input int nb, input int nic);
        sa_if.cfg_n_blk = 4'(nb);
        sa_if.cfg_n_ic  = 16'(nic);
        sa_if.start     = 1'b1;
        tick(1);
        sa_if.start     = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"},    int'(sa_if.busy),    0);
        chk({tag, "_sum_rdy"}, int'(sa_if.sum_rdy), 0);
        chk({tag, "_in_rstp"}, int'(sa_if.in_rstp), 0);
        chk({tag, "_in_sel"},  int'(sa_if.in_sel),  0);
        chk({tag, "_y_vld"},   int'(sa_if.y_vld),   0);
        chk({tag, "_y_blk"},   int'(sa_if.y_blk),   0);
        chk({tag, "_done"},    int'(sa_if.done),    0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int s, t0;
        int exp_rstp[6];
        int exp_sel[6];
        exp_rstp = '{1, 1, 1, 0, 0, 0};
        exp_sel  = '{0, 1, 2, 0, 1, 2};
        sa_if.start = 1'b0; sa_if.cfg_n_blk = '0; sa_if.cfg_n_ic = '0;
        sa_if.sum_vld = 1'b0; sa_if.out_pop = 1'b0;

        #2;
        chk_reset_outs("rst");
        tick(2);
        rstn = 1'b1;
        tick(2);

        // n_blk=8, n_ic=1; out_pop held so credits never run out
        clear_logs();
        sa_if.out_pop = 1'b1;
        sa_if.sum_vld = 1'b1;
        s = cyc;
        start_tile(8, 1);
        wait_done("t1", 80);
        sa_if.sum_vld = 1'b0;
        chk("t1_acc_cnt", acc_q.size(), 8);
        chk("t1_y_cnt", ycyc_q.size(), 8);
        t0 = (acc_q.size() > 0) ? acc_q[0] : -1;
        chk("t1_first_acc", t0, s + 1);
        for (int i = 0; i < acc_q.size() && i < 8; i++) begin
            chk($sformatf("t1_acc%0d", i), acc_q[i], s + 1 + i);
            chk($sformatf("t1_rstp%0d", i), rstp_q[i], 1);
            chk($sformatf("t1_sel%0d", i), sel_q[i], i);
        end
        for (int i = 0; i < ycyc_q.size() && i < 8; i++) begin
            chk($sformatf("t1_ycyc%0d", i), ycyc_q[i], s + 1 + 19 + i);
            chk($sformatf("t1_yblk%0d", i), yblk_q[i], i);
        end
        if (done_q.size() > 0) chk("t1_done_cyc", done_q[0], s + 1 + 27);
        tick(3);

        // n_blk=3, n_ic=2: only the second chunk produces results
        clear_logs();
        sa_if.sum_vld = 1'b1;
        s = cyc;
        start_tile(3, 2);
        wait_done("t2", 80);
        sa_if.sum_vld = 1'b0;
        chk("t2_acc_cnt", acc_q.size(), 6);
        for (int i = 0; i < rstp_q.size() && i < 6; i++) begin
            chk($sformatf("t2_rstp%0d", i), rstp_q[i], exp_rstp[i]);
            chk($sformatf("t2_sel%0d", i), sel_q[i], exp_sel[i]);
        end
        chk("t2_y_cnt", ycyc_q.size(), 3);
        for (int i = 0; i < ycyc_q.size() && i < 3; i++) begin
            chk($sformatf("t2_ycyc%0d", i), ycyc_q[i], s + 1 + 3 + i + LAT);
            chk($sformatf("t2_yblk%0d", i), yblk_q[i], i);
        end
        if (done_q.size() > 0) chk("t2_done_cyc", done_q[0], s + 1 + 5 + LAT + 1);
        tick(3);

        // credit exhaustion with no out_pop
        clear_logs();
        sa_if.out_pop = 1'b0;
        sa_if.sum_vld = 1'b1;
        start_tile(8, 1);
        tick(10);
        chk("t3_acc_no_pop", acc_q.size(), 4);
        chk("t3_rdy_stall", int'(sa_if.sum_rdy), 0);
        sa_if.out_pop = 1'b1; tick(1); sa_if.out_pop = 1'b0;
        tick(4);
        chk("t3_acc_one_pop", acc_q.size(), 5);
        chk("t3_rdy_stall2", int'(sa_if.sum_rdy), 0);
        sa_if.sum_vld = 1'b0;
        sa_if.out_pop = 1'b1; tick(1); sa_if.out_pop = 1'b0;
        tick(2);
        chk("t3_acc_idle_pop", acc_q.size(), 5);
        chk("t3_rdy_credit1", int'(sa_if.sum_rdy), 1);
        // final beat and out_pop together at credits=1
        sa_if.sum_vld = 1'b1;
        sa_if.out_pop = 1'b1; tick(1); sa_if.out_pop = 1'b0;
        tick(3);
        chk("t3_acc_simul", acc_q.size(), 7);
        chk("t3_rdy_stall3", int'(sa_if.sum_rdy), 0);
        sa_if.out_pop = 1'b1; tick(1); sa_if.out_pop = 1'b0;
        tick(2);
        chk("t3_acc_last", acc_q.size(), 8);
        sa_if.sum_vld = 1'b0;
        sa_if.out_pop = 1'b1; tick(6); sa_if.out_pop = 1'b0;
        wait_done("t3", 80);
        chk("t3_y_cnt", ycyc_q.size(), 8);
        for (int i = 0; i < yblk_q.size() && i < 8; i++)
            chk($sformatf("t3_yblk%0d", i), yblk_q[i], i);
        tick(3);

        // zero-size tile; second start while busy is ignored
        clear_logs();
        sa_if.sum_vld = 1'b1;
        sa_if.cfg_n_blk = 4'd8;
        sa_if.cfg_n_ic  = 16'd0;
        sa_if.start = 1'b1;
        s = cyc;
        tick(1);
        chk("t4_busy_s1", int'(sa_if.busy), 1);
        chk("t4_rdy_s1", int'(sa_if.sum_rdy), 0);
        tick(1);
        sa_if.start = 1'b0;
        chk("t4_done_s2", int'(sa_if.done), 1);
        chk("t4_busy_s2", int'(sa_if.busy), 0);
        tick(10);
        sa_if.sum_vld = 1'b0;
        chk("t4_done_cnt", done_q.size(), 1);
        if (done_q.size() > 0) chk("t4_done_cyc", done_q[0], s + 2);
        chk("t4_acc_cnt", acc_q.size(), 0);

        // asynchronous reset in the middle of RUN with final tokens in flight
        sa_if.out_pop = 1'b1;
        sa_if.sum_vld = 1'b1;
        start_tile(8, 2);
        tick(12);
        chk("t5_busy_pre", int'(sa_if.busy), 1);
        #3;
        rstn = 1'b0;
        #1;
        chk_reset_outs("t5_rst");
        @(posedge clk); #1;
        sa_if.sum_vld = 1'b0;
        rstn = 1'b1;
        tick(1);
        clear_logs();
        tick(40);
        chk("t5_no_y", ycyc_q.size(), 0);
        chk("t5_no_done", done_q.size(), 0);

        // clean tile after reset
        clear_logs();
        sa_if.sum_vld = 1'b1;
        s = cyc;
        start_tile(2, 1);
        wait_done("t6", 60);
        sa_if.sum_vld = 1'b0;
        chk("t6_acc_cnt", acc_q.size(), 2);
        for (int i = 0; i < rstp_q.size() && i < 2; i++) begin
            chk($sformatf("t6_rstp%0d", i), rstp_q[i], 1);
            chk($sformatf("t6_sel%0d", i), sel_q[i], i);
        end
        chk("t6_y_cnt", ycyc_q.size(), 2);
        for (int i = 0; i < ycyc_q.size() && i < 2; i++)
            chk($sformatf("t6_ycyc%0d", i), ycyc_q[i], s + 1 + i + LAT);
        if (done_q.size() > 0) chk("t6_done_cyc", done_q[0], s + 1 + 1 + LAT + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
